booth_seq_multiplier: RTL and testbench



---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_recoder.sv | 29 ++
 rtl/booth_seq_multiplier.sv | 118 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
// Holds the recoded digit encoding (3-bit two's complement), the control
// state encoding and the default operand width.
package booth_pkg;

   localparam int DEFAULT_WIDTH = 16;

   // Recoded Booth digit, 3-bit two's complement in {-2,-1,0,+1,+2}
   localparam logic [2:0] BOOTH_ZERO = 3'b000;
   localparam logic [2:0] BOOTH_P1   = 3'b001;
   localparam logic [2:0] BOOTH_P2   = 3'b010;
   localparam logic [2:0] BOOTH_M2   = 3'b110;
   localparam logic [2:0] BOOTH_M1   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder.
// Maps the 3-bit multiplier window {b(2i+1), b(2i), b(2i-1)} to a signed
// digit in {-2,-1,0,+1,+2} using the encoding from booth_pkg.
// Ports:
//   window : 3-bit multiplier window
//   digit  : recoded digit (3-bit two's complement)
module booth_recoder
   import booth_pkg::*;
(
   input  logic [2:0] window,
   output logic [2:0] digit
);

   always_comb begin
      digit = BOOTH_ZERO;
      case (window)
         3'b000:  digit = BOOTH_ZERO;
         3'b001:  digit = BOOTH_P1;
         3'b010:  digit = BOOTH_P1;
         3'b011:  digit = BOOTH_P2;
         3'b100:  digit = BOOTH_M2;
         3'b101:  digit = BOOTH_M1;
         3'b110:  digit = BOOTH_M1;
         3'b111:  digit = BOOTH_ZERO;
         default: digit = BOOTH_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier.
// Retires two multiplier bits per cycle; a signed WIDTH x WIDTH product is
// available WIDTH/2 RUN cycles after an accepted start.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset (priority over start)
//   start        : request a multiply; honoured only in IDLE or DONE
//   multiplicand : signed operand A, captured on accepted start
//   multiplier   : signed operand B, captured on accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse when product becomes valid
//   product      : signed A*B, held until a later multiply completes
module booth_seq_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int ACC_W = WIDTH + 2;                 // holds +-2A without wrap
   localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

   state_t state, nextState;

   logic signed [WIDTH-1:0]       aReg;
   logic signed [ACC_W-1:0]       accHi;
   logic        [WIDTH-1:0]       bSh;
   logic                          prevBit;
   logic        [CNT_W-1:0]       count;
   logic        [2*WIDTH-1:0]     productReg;

   logic        [2:0]             recDigit;
   logic signed [ACC_W-1:0]       aExt;
   logic signed [ACC_W-1:0]       ppMag;
   logic signed [ACC_W-1:0]       ppAdd;
   logic                          ppNeg;
   logic signed [ACC_W-1:0]       accSum;
   logic signed [ACC_W+WIDTH-1:0] shifted;
   logic                          accept;
   logic                          lastIter;

   booth_recoder uRecoder (
      .window ({bSh[1], bSh[0], prevBit}),
      .digit  (recDigit)
   );

   // Partial-product select: magnitude is A or 2A, negation is folded into
   // the accumulator add as invert plus carry-in.
   always_comb begin
      aExt  = {{2{aReg[WIDTH-1]}}, aReg};
      ppMag = '0;
      ppNeg = 1'b0;
      case (recDigit)
         BOOTH_P1: ppMag = aExt;
         BOOTH_P2: ppMag = aExt <<< 1;
         BOOTH_M1: begin ppMag = aExt;       ppNeg = 1'b1; end
         BOOTH_M2: begin ppMag = aExt <<< 1; ppNeg = 1'b1; end
         default:  ppMag = '0;
      endcase
      ppAdd   = ppNeg ? ~ppMag : ppMag;
      accSum  = accHi + ppAdd + {{(ACC_W-1){1'b0}}, ppNeg};
      shifted = $signed({accSum, bSh}) >>> 2;
   end

   always_comb begin
      lastIter  = (count == CNT_W'(WIDTH / 2 - 1));
      accept    = start && (state == ST_IDLE || state == ST_DONE);
      nextState = state;
      unique case (state)
         ST_IDLE: if (start)    nextState = ST_RUN;
         ST_RUN:  if (lastIter) nextState = ST_DONE;
         ST_DONE: nextState = start ? ST_RUN : ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= nextState;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aReg       <= '0;
         accHi      <= '0;
         bSh        <= '0;
         prevBit    <= 1'b0;
         count      <= '0;
         productReg <= '0;
      end else if (accept) begin
         aReg    <= multiplicand;
         bSh     <= multiplier;
         accHi   <= '0;
         prevBit <= 1'b0;
         count   <= '0;
      end else if (state == ST_RUN) begin
         accHi   <= shifted[ACC_W+WIDTH-1:WIDTH];
         bSh     <= shifted[WIDTH-1:0];
         prevBit <= bSh[1];
         count   <= count + CNT_W'(1);
         // After the final shift the low 2*WIDTH bits are the exact product
         if (lastIter) productReg <= shifted[2*WIDTH-1:0];
      end
   end

   assign busy    = (state == ST_RUN);
   assign done    = (state == ST_DONE);
   assign product = productReg;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic signed [W-1:0] mcand = '0;
   logic signed [W-1:0] mplier = '0;
   logic                busy;
   logic                done;
   logic [2*W-1:0]      product;

   int errors = 0;
   int checks = 0;

   booth_seq_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (mcand),
      .multiplier   (mplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: a multiply accepted when not busy finishes W/2 cycles
   // later with the arithmetic product of the operands seen at acceptance.
   int             mBusyLeft = 0;
   bit             mDone = 0;
   logic [2*W-1:0] mProd = '0;
   logic [2*W-1:0] mPending = '0;
   bit             modelOn = 0;

   always @(posedge clk) begin
      if (rst) begin
         mBusyLeft = 0;
         mDone     = 0;
         mProd     = '0;
      end else if (mBusyLeft > 0) begin
         mBusyLeft = mBusyLeft - 1;
         mDone     = (mBusyLeft == 0);
         if (mDone) mProd = mPending;
      end else begin
         mDone = 0;
         if (start) begin
            mPending  = (2*W)'(longint'(mcand) * longint'(mplier));
            mBusyLeft = W / 2;
         end
      end
   end

   always @(negedge clk) begin
      if (modelOn) begin
         chk("busy", 64'(busy), 64'(mBusyLeft > 0));
         chk("done", 64'(done), 64'(mDone));
         if (mBusyLeft == 0) chk("product", 64'(product), 64'(mProd));
         checks++;
         if (dut.recDigit == 3'b011 || dut.recDigit == 3'b100 || dut.recDigit == 3'b101) begin
            errors++;
            $display("FAIL digit_legal: got %b required one of 000 001 010 110 111", dut.recDigit);
         end
      end
   end

   function automatic logic signed [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return {1'b1, {(W-1){1'b0}}};
         1:       return {1'b0, {(W-1){1'b1}}};
         2:       return '0;
         3:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   // Start one multiply; returns cycles until done and busy cycles seen.
   task automatic runMul(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         output int lat, output int busyCnt);
      @(negedge clk);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      lat     = 0;
      busyCnt = 0;
      while (lat < 30) begin
         @(negedge clk);
         start  = 1'b0;
         mcand  = pick();
         mplier = pick();
         lat++;
         if (busy) busyCnt++;
         if (done) break;
      end
      if (!done) chk("done_timeout", 64'(lat), 64'(W / 2 + 1));
   endtask

   int lat, bc, dCnt, cyc, lastDone, gapIdx;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", 64'(product), 64'd0);
      rst = 1'b0;
      modelOn = 1;

      // Basic latency and value
      runMul(16'sd3, 16'sd5, lat, bc);
      chk("t1_latency", 64'(lat), 64'd9);
      chk("t1_busy_cycles", 64'(bc), 64'd8);
      chk("t1_product", 64'(product), 64'h0000000F);

      // Extremes
      runMul(-16'sd32768, -16'sd32768, lat, bc);
      chk("t2_minmin", 64'(product), 64'h40000000);
      runMul(16'sd32767, -16'sd32768, lat, bc);
      chk("t2_maxmin", 64'(product), 64'hC0008000);
      runMul(-16'sd1, -16'sd1, lat, bc);
      chk("t2_m1m1", 64'(product), 64'h00000001);

      // start held high: back-to-back multiplies every 9 cycles
      @(negedge clk);
      start = 1'b1; mcand = 16'sd7; mplier = -16'sd3;
      dCnt = 0; lastDone = 0;
      for (int i = 1; i <= 30 && dCnt < 3; i++) begin
         @(negedge clk);
         if (done) begin
            dCnt++;
            chk("t3_product", 64'(product), 64'hFFFFFFEB);
            chk("t3_gap", 64'(i - lastDone), 64'd9);
            lastDone = i;
         end
      end
      chk("t3_done_count", 64'(dCnt), 64'd3);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // start during RUN is ignored
      @(negedge clk);
      start = 1'b1; mcand = 16'sd100; mplier = 16'sd200;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (lat == 3) begin start = 1'b1; mcand = 16'sd1; mplier = 16'sd1; end
         else          start = 1'b0;
         if (done) break;
      end
      chk("t4_latency", 64'(lat), 64'd9);
      chk("t4_product", 64'(product), 64'h00004E20);
      repeat (12) @(negedge clk);

      // Reset mid-RUN
      @(negedge clk);
      start = 1'b1; mcand = 16'sd1234; mplier = -16'sd77;
      repeat (4) begin @(negedge clk); start = 1'b0; end
      chk("t5_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_product", 64'(product), 64'd0);
      runMul(-16'sd7, 16'sd9, lat, bc);
      chk("t5_after", 64'(product), 64'hFFFFFFC1);
      repeat (3) @(negedge clk);

      // Random operands, start held so multiplies run back-to-back
      dCnt = 0; cyc = 0;
      start = 1'b1; mcand = pick(); mplier = pick();
      while (dCnt < 10000 && cyc < 10000 * 9 + 50) begin
         @(negedge clk);
         cyc++;
         if (done) dCnt++;
         mcand  = pick();
         mplier = pick();
      end
      start = 1'b0;
      chk("t6_done_count", 64'(dCnt), 64'd10000);
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
